// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file port arbiter: arbitration state encoding,
// access-direction constants and default data/address widths.
package regfile_arb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;

  localparam logic RF_WRITE = 1'b1;
  localparam logic RF_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_port_arbiter.sv
// Shares the single access port of the register file between two requesters
// (port 0: writeback/ALU side, port 1: load/debug side). One access per cycle,
// round-robin with an optional lock that keeps ownership for up to MAX_BURST
// consecutive accesses while the other side waits.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   reqN, lockN, rwN       per-requester request, burst lock, 1=write/0=read
//   addrN, wdataN          per-requester address and write data
//   gntN                   requester owns the port this cycle
//   ackN                   one-cycle pulse the cycle after each performed access
//   rdataN                 read data captured on the access edge, held otherwise
//   rf_en/rw/addr/wdata    muxed access strobe and fields towards the register file
//   rf_rdata               combinational read data from the register file
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rf_en,
  output logic              rf_rw,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);
  localparam logic [CNT_W:0]   BURST_LIM = (CNT_W + 1)'(MAX_BURST);

  arb_state_e       r_state, w_state_nxt;
  logic             r_last_owner, w_last_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic             r_ack0, r_ack1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  logic              w_own0, w_own1;
  logic              w_req_own, w_lock_own, w_req_oth, w_rw_own;
  logic [ADDR_W-1:0] w_addr_own;
  logic [DATA_W-1:0] w_wdata_own;
  logic              w_access, w_last_burst, w_exit;
  arb_state_e        w_other;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);

  // Owner-side view of the request inputs; all zero in IDLE so nothing strobes.
  always_comb begin
    w_req_own   = 1'b0;
    w_lock_own  = 1'b0;
    w_req_oth   = 1'b0;
    w_rw_own    = RF_READ;
    w_addr_own  = '0;
    w_wdata_own = '0;
    w_other     = IDLE;
    unique case (r_state)
      OWN0: begin
        w_req_own   = req0;
        w_lock_own  = lock0;
        w_req_oth   = req1;
        w_rw_own    = rw0;
        w_addr_own  = addr0;
        w_wdata_own = wdata0;
        w_other     = OWN1;
      end
      OWN1: begin
        w_req_own   = req1;
        w_lock_own  = lock1;
        w_req_oth   = req0;
        w_rw_own    = rw1;
        w_addr_own  = addr1;
        w_wdata_own = wdata1;
        w_other     = OWN0;
      end
      default: ;
    endcase
  end

  assign w_access     = w_req_own;
  assign w_last_burst = (({1'b0, r_burst_cnt} + 1'b1) == BURST_LIM);

  assign rf_en    = w_access;
  assign rf_rw    = w_access & w_rw_own;
  assign rf_addr  = w_access ? w_addr_own : '0;
  assign rf_wdata = w_access ? w_wdata_own : '0;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_exit           = 1'b0;
    unique case (r_state)
      IDLE: begin
        // last_owner resets to 1 so port 0 wins the first contested grant.
        if (req0 && req1) begin
          w_state_nxt = r_last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          w_state_nxt = OWN0;
        end else if (req1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!w_req_own) begin
          w_exit      = 1'b1;
          w_state_nxt = w_req_oth ? w_other : IDLE;
        end else if (w_req_oth && (!w_lock_own || w_last_burst)) begin
          // Hand over on the same edge as the access: no bubble.
          w_exit      = 1'b1;
          w_state_nxt = w_other;
        end else if (r_burst_cnt != CNT_MAX) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
        if (w_exit) begin
          w_last_owner_nxt = w_own1;
          w_burst_cnt_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_ack0       <= w_access & w_own0;
      r_ack1       <= w_access & w_own1;
      if (w_access && w_own0 && (w_rw_own == RF_READ)) r_rdata0 <= rf_rdata;
      if (w_access && w_own1 && (w_rw_own == RF_READ)) r_rdata1 <= rf_rdata;
    end
  end

  assign gnt0   = w_own0;
  assign gnt1   = w_own1;
  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small behavioural register file.
// Unwritten registers read as 16'hBE00 + index.
module tb_regfile_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, lock0, lock1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rf_en, rf_rw;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_BURST(4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .lock0   (lock0),
    .lock1   (lock1),
    .rw0     (rw0),
    .rw1     (rw1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .ack0    (ack0),
    .ack1    (ack1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .rf_en   (rf_en),
    .rf_rw   (rf_rw),
    .rf_addr (rf_addr),
    .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  // Register file model: preloaded on the first edge (DUT held in reset then).
  logic [DW-1:0] mem [8];
  int            cyc;
  assign rf_rdata = mem[rf_addr];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'hBE00 + 16'(i);
    end else if (rf_en && rf_rw) begin
      mem[rf_addr] <= rf_wdata;
    end
    cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;

    // 1: reset with a pending request, then first grant and access.
    req0 = 1; rw0 = 0; addr0 = 3'd5;
    tick();
    tick();
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_ack0", ack0, 1'b0);
    check_eq("rst_rdata0", rdata0, 16'h0);
    check_eq("rst_rf_en", rf_en, 1'b0);
    rst_n = 1;
    tick();
    check_eq("t1_gnt0", gnt0, 1'b1);
    check_eq("t1_ack0_early", ack0, 1'b0);
    check_eq("t1_rf_en", rf_en, 1'b1);
    check_eq("t1_rf_rw", rf_rw, 1'b0);
    check_eq("t1_rf_addr", rf_addr, 3'd5);
    tick();
    check_eq("t1_ack0", ack0, 1'b1);
    check_eq("t1_rdata0", rdata0, 16'hBE05);
    req0 = 0;
    #1;
    check_eq("t1_rf_en_drop", rf_en, 1'b0);
    tick();
    check_eq("t1_ack0_end", ack0, 1'b0);
    check_eq("t1_gnt0_end", gnt0, 1'b0);

    // 2: write then read back r3 from port 0.
    req0 = 1; rw0 = 1; addr0 = 3'd3; wdata0 = 16'hA5A5;
    tick();
    check_eq("t2_gnt0", gnt0, 1'b1);
    check_eq("t2_rf_rw", rf_rw, 1'b1);
    check_eq("t2_rf_addr", rf_addr, 3'd3);
    check_eq("t2_rf_wdata", rf_wdata, 16'hA5A5);
    tick();
    check_eq("t2_wr_ack0", ack0, 1'b1);
    rw0 = 0; wdata0 = '0;
    tick();
    check_eq("t2_rd_ack0", ack0, 1'b1);
    check_eq("t2_rdata0", rdata0, 16'hA5A5);
    req0 = 0;
    tick();
    check_eq("t2_ack0_end", ack0, 1'b0);
    check_eq("t2_rdata0_hold", rdata0, 16'hA5A5);

    // 3: both requesting, no lock -> strict alternation starting with port 0.
    do_reset();
    req0 = 1; rw0 = 0; addr0 = 3'd3;
    req1 = 1; rw1 = 0; addr1 = 3'd5;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check_eq($sformatf("t3_gnt0_%0d", n), gnt0, (n % 2) == 1);
      check_eq($sformatf("t3_gnt1_%0d", n), gnt1, (n % 2) == 0);
      check_eq($sformatf("t3_ack0_%0d", n), ack0, (n > 1) && ((n % 2) == 0));
      check_eq($sformatf("t3_ack1_%0d", n), ack1, (n > 1) && ((n % 2) == 1));
      if (n == 2) check_eq("t3_rdata0", rdata0, 16'hA5A5);
      if (n == 3) check_eq("t3_rdata1", rdata1, 16'hBE05);
    end
    idle_inputs();
    tick();
    check_eq("t3_gnt0_end", gnt0, 1'b0);
    check_eq("t3_gnt1_end", gnt1, 1'b0);
    check_eq("t3_ack0_end", ack0, 1'b0);

    // 4a: locked burst with contender -> exactly four port-0 accesses.
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 3'd3;
    req1 = 1; addr1 = 3'd5;
    tick();
    check_eq("t4_gnt0_first", gnt0, 1'b1);
    for (int n = 2; n <= 5; n++) begin
      tick();
      check_eq($sformatf("t4_ack0_%0d", n), ack0, 1'b1);
      check_eq($sformatf("t4_gnt0_%0d", n), gnt0, n < 5);
      check_eq($sformatf("t4_gnt1_%0d", n), gnt1, n == 5);
    end
    tick();
    check_eq("t4_ack1", ack1, 1'b1);
    check_eq("t4_ack0_after", ack0, 1'b0);
    idle_inputs();
    tick();
    tick();

    // 4b: locked lone requester keeps the port beyond MAX_BURST.
    req0 = 1; lock0 = 1; addr0 = 3'd3;
    tick();
    for (int n = 2; n <= 8; n++) begin
      tick();
      check_eq($sformatf("t4b_ack0_%0d", n), ack0, 1'b1);
      check_eq($sformatf("t4b_gnt0_%0d", n), gnt0, 1'b1);
    end
    idle_inputs();
    tick();

    // 5: asynchronous reset while port 1 is writing.
    req1 = 1; rw1 = 1; addr1 = 3'd6; wdata1 = 16'h1234;
    tick();
    check_eq("t5_gnt1", gnt1, 1'b1);
    check_eq("t5_rf_en", rf_en, 1'b1);
    check_eq("t5_rf_wdata", rf_wdata, 16'h1234);
    tick();
    check_eq("t5_ack1", ack1, 1'b1);
    check_eq("t5_mem6", mem[6], 16'h1234);
    #1;
    rst_n = 0;
    #1;
    check_eq("t5_async_gnt1", gnt1, 1'b0);
    check_eq("t5_async_ack1", ack1, 1'b0);
    check_eq("t5_async_rf_en", rf_en, 1'b0);
    tick();
    idle_inputs();
    rst_n = 1;
    req0 = 1; addr0 = 3'd6;
    req1 = 1; addr1 = 3'd6;
    tick();
    check_eq("t5_first_gnt0", gnt0, 1'b1);
    check_eq("t5_first_gnt1", gnt1, 1'b0);
    req1 = 0;
    tick();
    check_eq("t5_ack0", ack0, 1'b1);
    check_eq("t5_rdata0", rdata0, 16'h1234);

    // 6: owner drops while the other raises in the same cycle.
    req0 = 0;
    req1 = 1; rw1 = 0; addr1 = 3'd6;
    #1;
    check_eq("t6_rf_en_drop", rf_en, 1'b0);
    tick();
    check_eq("t6_ack0", ack0, 1'b0);
    check_eq("t6_ack1", ack1, 1'b0);
    check_eq("t6_gnt0", gnt0, 1'b0);
    check_eq("t6_gnt1", gnt1, 1'b1);
    check_eq("t6_rf_en", rf_en, 1'b1);
    check_eq("t6_rf_addr", rf_addr, 3'd6);
    tick();
    check_eq("t6_ack1_rd", ack1, 1'b1);
    check_eq("t6_rdata1", rdata1, 16'h1234);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
